// File: rtl/arith_pkg.sv
// Shared types for the sequential arithmetic unit.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   mode_t  - operation select carried on the m port
//   state_t - control FSM states of seq_arith_unit
package arith_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_MULT = 2'b10,
        MODE_MAC  = 2'b11
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/mult_seq_core.sv
// Shift-add multiplier engine: prod = acc_init + a*b (mod 2^(2N)), LSB of b first.
// Latency: done pulses N-1 cycles after the load cycle (the load edge handles bit 0).
// Backpressure: none; load is only honoured while idle, the owner must not reload early.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load      - capture a, b, acc_init and start iterating
//   a, b      - N-bit unsigned multiplicand / multiplier
//   acc_init  - 2N-bit accumulator preload (0 for plain multiply)
//   busy      - iterations in progress
//   done      - one-cycle pulse, prod is final while it is high
//   prod      - 2N-bit accumulator value
module mult_seq_core #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [2*N-1:0] acc_init,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] prod
);

    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] mcand_q;
    logic [N-1:0]   mplier_q;
    logic [2*N-1:0] acc_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;

    logic [2*N-1:0] a_ext_d;
    logic [2*N-1:0] pp_load_d;
    logic [2*N-1:0] pp_iter_d;

    assign a_ext_d   = {{N{1'b0}}, a};
    // Bit 0 of the multiplier is consumed on the load edge so that the final
    // product is ready one cycle before the owner must publish it.
    assign pp_load_d = b[0] ? a_ext_d : '0;
    assign pp_iter_d = mplier_q[0] ? mcand_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q && load) begin
                acc_q    <= acc_init + pp_load_d;
                mcand_q  <= a_ext_d << 1;
                mplier_q <= b >> 1;
                cnt_q    <= CW'(1);
                busy_q   <= 1'b1;
            end else if (busy_q) begin
                acc_q    <= acc_q + pp_iter_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign prod = acc_q;

endmodule

// File: rtl/seq_arith_unit.sv
// Clocked add/sub/mult/mac unit with start/busy/done handshake and registered result.
// Latency: add/sub 1 cycle after start accept, mult/mac N cycles.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
//
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   start    - request; accepted only when busy=0
//   m        - mode: 00 add, 01 sub, 10 mult, 11 mac
//   X, Y     - N-bit unsigned operands
//   busy     - operation in flight
//   done     - one-cycle pulse when Z is updated
//   Z        - 2N-bit registered result, held between done pulses
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     m,
    input  logic [N-1:0]   X,
    input  logic [N-1:0]   Y,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] Z
);

    state_t         state_q;
    mode_t          mode_q;
    logic [N-1:0]   x_q;
    logic [N-1:0]   y_q;
    logic [2*N-1:0] z_q;
    logic           busy_q;
    logic           done_q;

    mode_t          m_in;
    logic           accept_d;
    logic           core_load_d;
    logic [2*N-1:0] core_init_d;
    logic           core_busy;
    logic           core_done;
    logic [2*N-1:0] core_prod;
    logic [N:0]     sum_add_d;
    logic [N:0]     sum_sub_d;
    logic [2*N-1:0] addsub_d;

    assign m_in     = mode_t'(m);
    assign accept_d = (state_q == IDLE) && start;

    // The multiplier takes operands straight from the ports on the accept
    // edge; mac seeds the accumulator with the current result.
    assign core_load_d = accept_d && m_in[1];
    assign core_init_d = (m_in == MODE_MAC) ? z_q : '0;

    // Subtraction in N+1 bits leaves the borrow in bit N.
    assign sum_add_d = {1'b0, x_q} + {1'b0, y_q};
    assign sum_sub_d = {1'b0, x_q} - {1'b0, y_q};
    assign addsub_d  = {{(N-1){1'b0}}, (mode_q == MODE_SUB) ? sum_sub_d : sum_add_d};

    mult_seq_core #(.N(N)) u_mult (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load_d),
        .a        (X),
        .b        (Y),
        .acc_init (core_init_d),
        .busy     (core_busy),
        .done     (core_done),
        .prod     (core_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_ADD;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= m_in;
                        x_q     <= X;
                        y_q     <= Y;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (!mode_q[1]) begin
                        z_q     <= addsub_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (core_done) begin
                        z_q     <= core_prod;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (!core_busy) begin
                        // Engine idle without a result: never expected, but
                        // drop back rather than wait forever.
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
module tb_seq_arith_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  m;
    logic [7:0]  X, Y;
    logic        busy, done;
    logic [15:0] Z;

    logic        start4;
    logic [1:0]  m4;
    logic [3:0]  X4, Y4;
    logic        busy4, done4;
    logic [7:0]  Z4;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] z_m    = '0;   // reference copy of Z for the N=8 unit
    logic [7:0]  z4_m   = '0;   // reference copy of Z for the N=4 unit

    always #5 clk = ~clk;

    seq_arith_unit #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .m(m), .X(X), .Y(Y),
        .busy(busy), .done(done), .Z(Z)
    );

    seq_arith_unit #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .m(m4), .X(X4), .Y(Y4),
        .busy(busy4), .done(done4), .Z(Z4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic int model(input int mode, input int x, input int y, input int zp, input int w);
        int full;
        full = 1 << (2 * w);
        case (mode)
            0:       return x + y;
            1:       return (x - y + (1 << (w + 1))) % (1 << (w + 1));
            2:       return x * y;
            default: return (zp + x * y) % full;
        endcase
    endfunction

    task automatic start_op(input int mode, input int x, input int y);
        start = 1'b1;
        m     = 2'(mode);
        X     = 8'(x);
        Y     = 8'(y);
    endtask

    // Called just before the accepting edge; returns #1 after the done edge.
    task automatic wait_done(input string tag, input int exp, input int lat, input int inj_at);
        int n    = 0;
        int bcnt = 0;
        bit seen = 1'b0;
        while (!seen && n < lat + 6) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) start = 1'b0;
            if (inj_at != 0 && n == inj_at) begin
                start = 1'b1; m = 2'b10; X = 8'h11; Y = 8'h22;
            end
            if (inj_at != 0 && n == inj_at + 1) start = 1'b0;
            if (busy) bcnt++;
            if (done) seen = 1'b1;
            else check($sformatf("%s hold@%0d", tag, n), Z, z_m);
        end
        check({tag, " done_seen"}, seen, 1);
        check({tag, " latency"}, n - 1, lat);
        check({tag, " busy_cycles"}, bcnt, lat);
        check({tag, " busy_at_done"}, busy, 0);
        check({tag, " Z"}, Z, exp);
        z_m = 16'(exp);
    endtask

    task automatic run4(input string tag, input int mode, input int x, input int y, input int lat);
        int n    = 0;
        bit seen = 1'b0;
        int exp;
        exp = model(mode, x, y, z4_m, 4);
        @(negedge clk);
        start4 = 1'b1; m4 = 2'(mode); X4 = 4'(x); Y4 = 4'(y);
        while (!seen && n < lat + 6) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) start4 = 1'b0;
            if (done4) seen = 1'b1;
        end
        check({tag, " done_seen"}, seen, 1);
        check({tag, " latency"}, n - 1, lat);
        check({tag, " Z"}, Z4, exp);
        z4_m = 8'(exp);
    endtask

    initial begin
        int dcnt;
        int exp;
        rst = 1'b1; start = 1'b0; m = '0; X = '0; Y = '0;
        start4 = 1'b0; m4 = '0; X4 = '0; Y4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst Z", Z, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst Z4", Z4, 0);
        rst = 1'b0;

        // Directed cases
        @(negedge clk); start_op(0, 200, 100); wait_done("add", 16'h012C, 1, 0);
        @(negedge clk); start_op(1, 5, 10);    wait_done("sub_borrow", 16'h01FB, 1, 0);
        @(negedge clk); start_op(1, 10, 5);    wait_done("sub", 16'h0005, 1, 0);
        @(negedge clk); start_op(2, 255, 255); wait_done("mult_max", 16'hFE01, 8, 0);
        @(negedge clk); start_op(3, 1, 1);     wait_done("mac", 16'hFE02, 8, 0);
        // Start held in the done cycle: accepted back-to-back
        start_op(3, 255, 255);                 wait_done("mac_b2b_wrap", 16'hFC03, 8, 0);

        // Start mid-multiply with other operands must be ignored
        @(negedge clk); start_op(2, 12, 34);   wait_done("mult_ignore", 12 * 34, 8, 3);
        dcnt = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("mult_ignore extra_done", dcnt, 0);
        check("mult_ignore Z_held", Z, z_m);

        // Reset during a multiply aborts it
        @(negedge clk); start_op(2, 77, 3);
        repeat (4) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort Z", Z, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        rst = 1'b0;
        z_m = '0; z4_m = '0;
        dcnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("abort no_done", dcnt, 0);
        check("abort Z_stays", Z, 0);

        // Narrow instance
        run4("n4_mult", 2, 15, 15, 4);
        check("n4_mult exact", Z4, 8'hE1);
        run4("n4_add", 0, 15, 15, 1);
        run4("n4_mac", 3, 15, 15, 4);
        run4("n4_sub", 1, 3, 9, 1);

        // Randomized operations, some back-to-back
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            int mode, x, y;
            mode = int'($urandom_range(0, 3));
            x    = int'($urandom_range(0, 255));
            y    = int'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) begin
                repeat (int'($urandom_range(0, 2))) @(posedge clk);
                @(negedge clk);
            end
            exp = model(mode, x, y, z_m, 8);
            start_op(mode, x, y);
            wait_done($sformatf("rnd%0d_m%0d", i, mode), exp, (mode >= 2) ? 8 : 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
